// File: rtl/bus_spi_master_if.sv
// CPU memory-bus port bundle for the SPI master responder.
interface bus_spi_master_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rd_req;
  logic        bus_wr_req;
  logic [31:0] bus_rdata;
  logic        bus_rd_ack;
  logic        bus_wr_ack;

  // CPU side: issues requests, receives acks and read data
  modport master (
    output bus_addr, bus_wdata, bus_be, bus_rd_req, bus_wr_req,
    input  bus_rdata, bus_rd_ack, bus_wr_ack
  );

  // Peripheral side
  modport slave (
    input  bus_addr, bus_wdata, bus_be, bus_rd_req, bus_wr_req,
    output bus_rdata, bus_rd_ack, bus_wr_ack
  );
endinterface

// File: rtl/bus_spi_master.sv
// Bus-mapped 8-bit SPI master, mode 0, MSB first.
// Registers: +0 CTRL (cs_en, busy, done, overrun), +4 DATA, +8 DIV.
// Read data is forced to zero outside the ack cycle so it can be OR-ed
// into the top-level read mux.
module bus_spi_master #(
  parameter logic [31:0] BUS_ADDR    = 32'h0200_0010,
  parameter logic [15:0] DEFAULT_DIV = 16'd5
) (
  input  logic             clk,
  input  logic             reset,
  bus_spi_master_if.slave  bus,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_l
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state;
  logic        cs_en;
  logic        done;
  logic        overrun;
  logic [15:0] div;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_data;

  // Word offset from the base; subtraction makes addresses below the base
  // wrap to large values so a single compare covers the whole window.
  logic [29:0] word_off;
  logic        hit;
  logic        busy;
  logic        rd_hit, wr_hit;
  logic        ctrl_wr, data_wr, div_wr, data_rd;
  logic [31:0] rd_val;

  assign word_off = bus.bus_addr[31:2] - BUS_ADDR[31:2];
  assign hit      = (word_off < 30'd3);
  assign busy     = (state != IDLE);
  assign rd_hit   = bus.bus_rd_req & hit;
  assign wr_hit   = bus.bus_wr_req & hit;
  assign ctrl_wr  = wr_hit & (word_off[1:0] == 2'd0);
  assign data_wr  = wr_hit & (word_off[1:0] == 2'd1) & bus.bus_be[0];
  assign div_wr   = wr_hit & (word_off[1:0] == 2'd2);
  assign data_rd  = rd_hit & (word_off[1:0] == 2'd1);

  logic unused_ok;
  assign unused_ok = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16], bus.bus_be[3:2]};

  // Register read mux, evaluated in the request cycle
  always_comb begin
    rd_val = '0;
    case (word_off[1:0])
      2'd0:    rd_val = {21'b0, overrun, done, busy, 7'b0, cs_en};
      2'd1:    rd_val = {24'b0, rx_data};
      2'd2:    rd_val = {16'b0, div};
      default: rd_val = '0;
    endcase
  end

  // Bus responder, control registers and the SCLK phase FSM. done is
  // touched by both the bus and the FSM, so they share one block; the
  // completion set is written last so it wins over a same-cycle read clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bus_rdata  <= '0;
      bus.bus_rd_ack <= 1'b0;
      bus.bus_wr_ack <= 1'b0;
      state          <= IDLE;
      cs_en          <= 1'b0;
      spi_cs_l       <= 1'b1;
      spi_sclk       <= 1'b0;
      spi_mosi       <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      div            <= DEFAULT_DIV;
      cnt            <= '0;
      bit_cnt        <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      rx_data        <= '0;
    end else begin
      bus.bus_rd_ack <= rd_hit;
      bus.bus_wr_ack <= wr_hit;
      bus.bus_rdata  <= rd_hit ? rd_val : 32'h0;

      if (ctrl_wr && bus.bus_be[0]) begin
        cs_en    <= bus.bus_wdata[0];
        spi_cs_l <= ~bus.bus_wdata[0];
      end
      if (ctrl_wr && bus.bus_be[1] && bus.bus_wdata[10])
        overrun <= 1'b0;

      if (div_wr && bus.bus_be[0]) div[7:0]  <= bus.bus_wdata[7:0];
      if (div_wr && bus.bus_be[1]) div[15:8] <= bus.bus_wdata[15:8];

      if (data_rd) done <= 1'b0;
      if (data_wr && busy) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (data_wr) begin
            tx_sh    <= bus.bus_wdata[7:0];
            spi_mosi <= bus.bus_wdata[7];
            spi_sclk <= 1'b0;
            done     <= 1'b0;
            cnt      <= div;
            bit_cnt  <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (cnt == 16'd0) begin
            spi_sclk <= 1'b1;
            rx_sh    <= {rx_sh[6:0], spi_miso};
            cnt      <= div;
            state    <= HIGH;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        HIGH: begin
          if (cnt == 16'd0) begin
            spi_sclk <= 1'b0;
            cnt      <= div;
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_sh;
              done     <= 1'b1;
              spi_mosi <= 1'b0;
              state    <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_sh    <= {tx_sh[6:0], 1'b0};
              spi_mosi <= tx_sh[6];
              state    <= LOW;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
